// File: rtl/hls_exec_perf_monitor.sv
// hls_exec_perf_monitor
// Passive performance monitor for one HLS ap_ctrl_hs module and one pipelined
// loop. It only observes handshake and loop FSM/pipeline signals and drives
// nothing back into the design under observation.
//
// Counters:
//   - module transactions and their latency (last and maximum)
//   - loop runs, the duration of the last run, iterations started and ended
//   - stall cycles (blocked first stage while a loop run is in progress)
// All counters saturate at 2**CNT_W-1. Once 'finish' is seen, every counter
// and busy flag freezes until reset.
//
// Parameters:
//   STATE_W  width of the loop FSM state vectors
//   CNT_W    width of every counter output
//
// Ports:
//   clock, reset (asynchronous, active-high), finish
//   ap_start/ap_ready/ap_done/ap_continue          module handshake
//   cur_state, iter_start_state, iter_end_state, quit_state   loop FSM
//   iter_start_/iter_end_/quit_ block and enable   pipeline qualifiers
//   loop_start/loop_ready/loop_done/loop_continue  loop block handshake
//   quit_at_end                                    quit requires an iteration end
//   mod_busy, mod_txn_count, mod_last_lat, mod_max_lat        module statistics
//   loop_busy, loop_run_count, iter_start_count, iter_end_count,
//   loop_last_cycles, stall_cycles, frozen                    loop statistics
//
// Build option:
//   HLS_MON_STALL_COUNT_EN  when defined, stall_cycles counts cycles with
//                           loop_busy, cur_state==iter_start_state and
//                           iter_start_block high. Otherwise it is tied to 0.

module hls_exec_perf_monitor #(
  parameter int STATE_W = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               finish,
  input  logic               ap_start,
  input  logic               ap_ready,
  input  logic               ap_done,
  input  logic               ap_continue,
  input  logic [STATE_W-1:0] cur_state,
  input  logic [STATE_W-1:0] iter_start_state,
  input  logic [STATE_W-1:0] iter_end_state,
  input  logic [STATE_W-1:0] quit_state,
  input  logic               iter_start_block,
  input  logic               iter_end_block,
  input  logic               quit_block,
  input  logic               iter_start_enable,
  input  logic               iter_end_enable,
  input  logic               quit_enable,
  input  logic               loop_start,
  input  logic               loop_ready,
  input  logic               loop_done,
  input  logic               loop_continue,
  input  logic               quit_at_end,
  output logic               mod_busy,
  output logic [CNT_W-1:0]   mod_txn_count,
  output logic [CNT_W-1:0]   mod_last_lat,
  output logic [CNT_W-1:0]   mod_max_lat,
  output logic               loop_busy,
  output logic [CNT_W-1:0]   loop_run_count,
  output logic [CNT_W-1:0]   iter_start_count,
  output logic [CNT_W-1:0]   iter_end_count,
  output logic [CNT_W-1:0]   loop_last_cycles,
  output logic [CNT_W-1:0]   stall_cycles,
  output logic               frozen
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  logic             accept, complete, mod_end;
  logic             iter_start_ev, iter_end_ev, quit_ev, loop_end;
  logic [CNT_W-1:0] mod_lat;       // cycles of the open transaction so far
  logic [CNT_W-1:0] loop_cyc;      // cycles of the open loop run so far
  logic [CNT_W-1:0] mod_lat_fin;
  logic [CNT_W-1:0] loop_cyc_fin;
  logic             quit_seen;     // loop has passed its exit test this run

  assign accept   = ap_start & ap_ready;
  assign complete = ap_done & ap_continue;
  // A completion only closes a transaction that is open or opens this cycle.
  assign mod_end  = complete & (mod_busy | accept);

  assign iter_start_ev = (cur_state == iter_start_state) & ~iter_start_block & iter_start_enable;
  assign iter_end_ev   = (cur_state == iter_end_state) & ~iter_end_block & iter_end_enable;
  assign quit_ev       = (cur_state == quit_state) & ~quit_block & quit_enable &
                         (~quit_at_end | iter_end_ev);
  assign loop_end      = loop_done & loop_continue & (loop_busy | loop_start);

  // The running counters are 0 while idle, so the +1 for the closing cycle
  // also yields 1 for a transaction/run that opens and closes in one cycle.
  assign mod_lat_fin  = sat_inc(mod_lat);
  assign loop_cyc_fin = sat_inc(loop_cyc);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      frozen           <= 1'b0;
      mod_busy         <= 1'b0;
      mod_lat          <= '0;
      mod_txn_count    <= '0;
      mod_last_lat     <= '0;
      mod_max_lat      <= '0;
      loop_busy        <= 1'b0;
      loop_cyc         <= '0;
      loop_run_count   <= '0;
      loop_last_cycles <= '0;
      iter_start_count <= '0;
      iter_end_count   <= '0;
      quit_seen        <= 1'b0;
    end else begin
      if (finish) frozen <= 1'b1;
      // Events in the finish cycle still count; freezing starts next cycle.
      if (!frozen) begin
        if (mod_end) begin
          mod_txn_count <= sat_inc(mod_txn_count);
          mod_last_lat  <= mod_lat_fin;
          if (mod_lat_fin > mod_max_lat) mod_max_lat <= mod_lat_fin;
          // Back-to-back: a new accept in the completing cycle opens the next one.
          mod_busy      <= mod_busy & accept;
          mod_lat       <= (mod_busy & accept) ? CNT_ONE : '0;
        end else if (accept && !mod_busy) begin
          mod_busy <= 1'b1;
          mod_lat  <= CNT_ONE;
        end else if (mod_busy) begin
          mod_lat <= sat_inc(mod_lat);
        end

        if (loop_end) begin
          loop_run_count   <= sat_inc(loop_run_count);
          loop_last_cycles <= loop_cyc_fin;
          loop_busy        <= 1'b0;
          loop_cyc         <= '0;
          quit_seen        <= 1'b0;
        end else begin
          if (loop_start && !loop_busy) begin
            loop_busy <= 1'b1;
            loop_cyc  <= CNT_ONE;
          end else if (loop_busy) begin
            loop_cyc <= sat_inc(loop_cyc);
          end
          // Iteration ends after the quit keep counting while the pipeline drains.
          if (quit_ev) quit_seen <= 1'b1;
        end

        if (iter_start_ev) iter_start_count <= sat_inc(iter_start_count);
        if (iter_end_ev)   iter_end_count   <= sat_inc(iter_end_count);
      end
    end
  end

`ifdef HLS_MON_STALL_COUNT_EN
  logic [CNT_W-1:0] stall_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
    end else if (loop_busy && (cur_state == iter_start_state) && iter_start_block && !frozen) begin
      stall_q <= sat_inc(stall_q);
    end
  end

  assign stall_cycles = stall_q;
`else
  assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_hls_exec_perf_monitor.sv
// Bench for hls_exec_perf_monitor: two instances (32-bit and 4-bit counters)
// share one set of directed inputs. A cycle-indexed reference model tracks
// unbounded event counts and timestamps; expected outputs are those values
// clamped to each instance's counter width. Literal checks pin the model.

module tb_hls_exec_perf_monitor;

  logic       clock = 1'b0;
  logic       reset, finish;
  logic       ap_start, ap_ready, ap_done, ap_continue;
  logic [0:0] cur_state, iter_start_state, iter_end_state, quit_state;
  logic       iter_start_block, iter_end_block, quit_block;
  logic       iter_start_enable, iter_end_enable, quit_enable;
  logic       loop_start, loop_ready, loop_done, loop_continue, quit_at_end;

  logic        d_mod_busy, d_loop_busy, d_frozen;
  logic [31:0] d_txn, d_last, d_max, d_runs, d_isc, d_iec, d_llc, d_stall;
  logic        s_mod_busy, s_loop_busy, s_frozen;
  logic [3:0]  s_txn, s_last, s_max, s_runs, s_isc, s_iec, s_llc, s_stall;

  always #5 clock = ~clock;

  hls_exec_perf_monitor #(.STATE_W(1), .CNT_W(32)) u_dut (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_busy(d_mod_busy), .mod_txn_count(d_txn), .mod_last_lat(d_last), .mod_max_lat(d_max),
    .loop_busy(d_loop_busy), .loop_run_count(d_runs), .iter_start_count(d_isc),
    .iter_end_count(d_iec), .loop_last_cycles(d_llc), .stall_cycles(d_stall), .frozen(d_frozen)
  );

  hls_exec_perf_monitor #(.STATE_W(1), .CNT_W(4)) u_sat (
    .clock(clock), .reset(reset), .finish(finish),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state),
    .iter_end_state(iter_end_state), .quit_state(quit_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block), .quit_block(quit_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable), .quit_enable(quit_enable),
    .loop_start(loop_start), .loop_ready(loop_ready), .loop_done(loop_done),
    .loop_continue(loop_continue), .quit_at_end(quit_at_end),
    .mod_busy(s_mod_busy), .mod_txn_count(s_txn), .mod_last_lat(s_last), .mod_max_lat(s_max),
    .loop_busy(s_loop_busy), .loop_run_count(s_runs), .iter_start_count(s_isc),
    .iter_end_count(s_iec), .loop_last_cycles(s_llc), .stall_cycles(s_stall), .frozen(s_frozen)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  longint m_cyc = 0;
  bit     m_busy = 0, l_busy = 0, m_frozen = 0;
  longint m_acc = 0, m_txn = 0, m_last = 0, m_max = 0;
  longint l_start = 0, l_runs = 0, l_last = 0;
  longint is_n = 0, ie_n = 0, st_n = 0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_busy = 0; l_busy = 0; m_frozen = 0;
      m_acc = 0; m_txn = 0; m_last = 0; m_max = 0;
      l_start = 0; l_runs = 0; l_last = 0;
      is_n = 0; ie_n = 0; st_n = 0;
    end else begin
      if (!m_frozen) begin
        bit acc, cmp, lend;
        longint lat;
        acc = ap_start && ap_ready;
        cmp = ap_done && ap_continue;
`ifdef HLS_MON_STALL_COUNT_EN
        if (l_busy && cur_state == iter_start_state && iter_start_block) st_n++;
`endif
        if (cmp && (m_busy || acc)) begin
          lat = m_busy ? (m_cyc - m_acc + 1) : 1;
          m_txn++;
          m_last = lat;
          if (lat > m_max) m_max = lat;
          m_busy = m_busy && acc;
          m_acc  = m_cyc;
        end else if (acc && !m_busy) begin
          m_busy = 1;
          m_acc  = m_cyc;
        end
        lend = loop_done && loop_continue && (l_busy || loop_start);
        if (lend) begin
          l_last = l_busy ? (m_cyc - l_start + 1) : 1;
          l_runs++;
          l_busy = 0;
        end else if (loop_start && !l_busy) begin
          l_busy  = 1;
          l_start = m_cyc;
        end
        if (cur_state == iter_start_state && !iter_start_block && iter_start_enable) is_n++;
        if (cur_state == iter_end_state && !iter_end_block && iter_end_enable) ie_n++;
      end
      if (finish) m_frozen = 1;
      m_cyc++;
    end
  end

  function automatic longint clamp(input longint v, input int w);
    longint mx;
    mx = (longint'(1) << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic cmp_inst(input string t, input int w, input logic mb, input longint txn,
                          input longint last, input longint mx, input logic lb, input longint runs,
                          input longint isc, input longint iec, input longint llc,
                          input longint stc, input logic fz);
    chk({t, ".mod_busy"},         longint'(mb), longint'(m_busy));
    chk({t, ".mod_txn_count"},    txn,  clamp(m_txn, w));
    chk({t, ".mod_last_lat"},     last, clamp(m_last, w));
    chk({t, ".mod_max_lat"},      mx,   clamp(m_max, w));
    chk({t, ".loop_busy"},        longint'(lb), longint'(l_busy));
    chk({t, ".loop_run_count"},   runs, clamp(l_runs, w));
    chk({t, ".iter_start_count"}, isc,  clamp(is_n, w));
    chk({t, ".iter_end_count"},   iec,  clamp(ie_n, w));
    chk({t, ".loop_last_cycles"}, llc,  clamp(l_last, w));
    chk({t, ".stall_cycles"},     stc,  clamp(st_n, w));
    chk({t, ".frozen"},           longint'(fz), longint'(m_frozen));
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      cmp_inst("w32", 32, d_mod_busy, d_txn, d_last, d_max, d_loop_busy, d_runs,
               d_isc, d_iec, d_llc, d_stall, d_frozen);
      cmp_inst("w4", 4, s_mod_busy, s_txn, s_last, s_max, s_loop_busy, s_runs,
               s_isc, s_iec, s_llc, s_stall, s_frozen);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic idle_inputs();
    finish = 0; ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1;
    cur_state = 1'b0; iter_start_state = 1'b0; iter_end_state = 1'b0; quit_state = 1'b0;
    iter_start_block = 0; iter_end_block = 0; quit_block = 0;
    iter_start_enable = 0; iter_end_enable = 0; quit_enable = 0;
    loop_start = 0; loop_ready = 0; loop_done = 0; loop_continue = 1; quit_at_end = 0;
  endtask

  task automatic pulse_accept(input bit done_too);
    ap_start = 1; ap_ready = 1; ap_done = done_too;
    tick();
    ap_start = 0; ap_ready = 0; ap_done = 0;
  endtask

  task automatic pulse_done();
    ap_done = 1;
    tick();
    ap_done = 0;
  endtask

  task automatic all_zero_w32(input string t);
    chk({t, ".busy"},  longint'(d_mod_busy), 0);
    chk({t, ".txn"},   d_txn, 0);
    chk({t, ".last"},  d_last, 0);
    chk({t, ".max"},   d_max, 0);
    chk({t, ".lbusy"}, longint'(d_loop_busy), 0);
    chk({t, ".runs"},  d_runs, 0);
    chk({t, ".isc"},   d_isc, 0);
    chk({t, ".iec"},   d_iec, 0);
    chk({t, ".llc"},   d_llc, 0);
    chk({t, ".stall"}, d_stall, 0);
    chk({t, ".frozen"}, longint'(d_frozen), 0);
    chk({t, ".w4txn"}, s_txn, 0);
  endtask

  longint exp_stall;

  initial begin
    idle_inputs();
    reset = 1;
    tick(2);
    chk_en = 1;
    all_zero_w32("reset");
    reset = 0;
    tick(5);

    // Single transaction: accept, three idle cycles, complete -> latency 5.
    pulse_accept(0);
    tick(3);
    pulse_done();
    chk("t1.last", d_last, 5);
    chk("t1.max",  d_max, 5);
    chk("t1.txn",  d_txn, 1);
    chk("t1.busy", longint'(d_mod_busy), 0);
    tick(2);

    // Back-to-back: latency 5 then 3, busy held across the shared cycle.
    pulse_accept(0);
    tick(3);
    pulse_accept(1);
    chk("t2.busy_mid", longint'(d_mod_busy), 1);
    tick(1);
    pulse_done();
    chk("t2.txn",  d_txn, 3);
    chk("t2.last", d_last, 3);
    chk("t2.max",  d_max, 5);
    tick(2);

    // Accept and complete together while idle -> latency 1.
    pulse_accept(1);
    chk("t2b.txn",  d_txn, 4);
    chk("t2b.last", d_last, 1);
    chk("t2b.max",  d_max, 5);
    tick(2);

    // Loop run: start@0, starts 1..8, ends 3..10 (quit@10), done@11.
    for (int c = 0; c <= 11; c++) begin
      loop_start        = (c == 0);
      iter_start_enable = (c >= 1 && c <= 8);
      iter_end_enable   = (c >= 3 && c <= 10);
      quit_enable       = (c == 10);
      loop_done         = (c == 11);
      tick();
    end
    idle_inputs();
    chk("t3.isc",  d_isc, 8);
    chk("t3.iec",  d_iec, 8);
    chk("t3.runs", d_runs, 1);
    chk("t3.llc",  d_llc, 12);
    chk("t3.lbusy", longint'(d_loop_busy), 0);
    tick(2);

    // Loop run with the first stage blocked for cycles 3..5.
    quit_at_end = 1;
    for (int c = 0; c <= 8; c++) begin
      loop_start        = (c == 0);
      iter_start_enable = (c >= 1 && c <= 7);
      iter_start_block  = (c >= 3 && c <= 5);
      quit_enable       = (c == 6);
      loop_done         = (c == 8);
      tick();
    end
    idle_inputs();
`ifdef HLS_MON_STALL_COUNT_EN
    exp_stall = 3;
`else
    exp_stall = 0;
`endif
    chk("t4.stall", d_stall, exp_stall);
    chk("t4.isc",   d_isc, 12);
    chk("t4.runs",  d_runs, 2);
    chk("t4.llc",   d_llc, 9);
    tick(2);

    // Twenty iteration starts outside a run: the 4-bit counter saturates.
    iter_start_enable = 1;
    tick(20);
    iter_start_enable = 0;
    chk("t5.isc_w32", d_isc, 32);
    chk("t5.isc_w4",  s_isc, 15);
    tick(2);

    // Long transaction of 20 cycles: 4-bit latency saturates at 15.
    pulse_accept(0);
    tick(18);
    pulse_done();
    chk("t6.last_w32", d_last, 20);
    chk("t6.max_w32",  d_max, 20);
    chk("t6.last_w4",  s_last, 15);
    chk("t6.max_w4",   s_max, 15);
    chk("t6.txn_w4",   s_txn, 5);
    tick(2);

    // finish together with an accept; later events are ignored.
    finish = 1;
    pulse_accept(0);
    finish = 0;
    tick(2);
    pulse_done();
    pulse_accept(1);
    iter_start_enable = 1; iter_end_enable = 1; loop_start = 1;
    tick(3);
    idle_inputs();
    tick(1);
    chk("t7.frozen", longint'(d_frozen), 1);
    chk("t7.busy",   longint'(d_mod_busy), 1);
    chk("t7.txn",    d_txn, 5);
    chk("t7.isc",    d_isc, 32);
    chk("t7.iec",    d_iec, 8);
    chk("t7.lbusy",  longint'(d_loop_busy), 0);

    // Asynchronous reset clears everything immediately.
    reset = 1;
    #1;
    all_zero_w32("t8");
    tick(1);
    reset = 0;
    tick(2);

    // Reset mid-transaction.
    pulse_accept(0);
    tick(2);
    chk("t9.busy_before", longint'(d_mod_busy), 1);
    reset = 1;
    #1;
    chk("t9.busy", longint'(d_mod_busy), 0);
    chk("t9.txn",  d_txn, 0);
    tick(1);
    reset = 0;
    tick(3);
    pulse_done();
    chk("t9.txn_after", d_txn, 0);
    tick(2);

    chk_en = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
